// File: rtl/outbox_uart_tx_pkg.sv
// Shared types and constants for the OUTBOX UART transmitter: FSM encoding,
// 8N1 frame geometry and the default baud divider.
package outbox_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_STOP_BITS  = 1;
  localparam int unsigned UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

  // 12 MHz system clock / 115200 baud
  localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd104;
  localparam int unsigned DEFAULT_LGFLEN          = 5;

  function automatic logic [23:0] baud_reload(input logic [23:0] cpb);
    return cpb - 24'd1;
  endfunction

  function automatic logic [31:0] frame_clocks(input logic [23:0] cpb);
    return UART_FRAME_BITS * {8'd0, cpb};
  endfunction

endpackage

// File: rtl/outbox_uart_tx_if.sv
// Client-facing bundle of the OUTBOX transmitter: push port, status flags,
// serial line and the dump window used by the display pipe.
interface outbox_uart_tx_if #(
  parameter int unsigned LGFLEN = 5
);
  logic              i_wr;
  logic [7:0]        i_data;
  logic              o_full;
  logic              o_empty_n;
  logic              o_ovf;
  logic              o_busy;
  logic              o_uart_tx;
  logic [LGFLEN-1:0] i_dmp_pos;
  logic [7:0]        o_dmp_data;
  logic              o_dmp_valid;

  modport master (
    output i_wr, i_data, i_dmp_pos,
    input  o_full, o_empty_n, o_ovf, o_busy, o_uart_tx, o_dmp_data, o_dmp_valid
  );

  modport slave (
    input  i_wr, i_data, i_dmp_pos,
    output o_full, o_empty_n, o_ovf, o_busy, o_uart_tx, o_dmp_data, o_dmp_valid
  );
endinterface

// File: rtl/outbox_uart_tx_txuart_core.sv
// 8N1 serializer: baud down-counter, shift register and frame FSM. A byte is
// taken over the ld_valid/ld_ready handshake whenever the FSM can start a frame.
module txuart_core
  import outbox_uart_tx_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ld_valid_i,
  input  logic [7:0] ld_data_i,
  output logic       ld_ready_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam logic [23:0] RELOAD   = baud_reload(CLOCKS_PER_BAUD);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state_q;
  logic [23:0]               baud_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [2:0]                idx_q;
  logic                      tx_q;
  logic                      baud_zero;

  assign baud_zero  = (baud_q == 24'd0);
  // A new byte can be taken from idle, or on the last stop-bit cycle so
  // queued frames follow each other with no idle gap.
  assign ld_ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_zero);
  assign busy_o     = (state_q != ST_IDLE);
  assign tx_o       = tx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      baud_q  <= 24'd0;
      shift_q <= '0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (ld_valid_i) begin
            shift_q <= ld_data_i;
            idx_q   <= 3'd0;
            baud_q  <= RELOAD;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          tx_q <= 1'b0;
          if (baud_zero) begin
            baud_q  <= RELOAD;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q - 24'd1;
          end
        end
        ST_DATA: begin
          tx_q <= shift_q[0];
          if (baud_zero) begin
            baud_q  <= RELOAD;
            shift_q <= shift_q >> 1;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == LAST_BIT) begin
              state_q <= ST_STOP;
            end
          end else begin
            baud_q <= baud_q - 24'd1;
          end
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (baud_zero) begin
            if (ld_valid_i) begin
              shift_q <= ld_data_i;
              idx_q   <= 3'd0;
              baud_q  <= RELOAD;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            baud_q <= baud_q - 24'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/outbox_uart_tx.sv
// OUTBOX buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
// Define OUTBOX_DUMP_EN to build the registered dump port over the queued bytes.
module outbox_uart_tx
  import outbox_uart_tx_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
  parameter int unsigned LGFLEN          = DEFAULT_LGFLEN
) (
  input  logic             clk,
  input  logic             reset_n,
  outbox_uart_tx_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << LGFLEN;

  logic [7:0]        mem [DEPTH];
  logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN:0]   count_q, count_d;
  logic              ovf_q;
  logic              full;
  logic              empty_n;
  logic              ld_ready;
  logic              pop;
  logic              push;

  assign full    = (count_q == (LGFLEN + 1)'(DEPTH));
  assign empty_n = (count_q != '0);
  assign pop     = empty_n && ld_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = bus.i_wr && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= bus.i_wr && !push;
    end
  end

  txuart_core #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .ld_valid_i(empty_n),
    .ld_data_i (mem[rd_ptr_q]),
    .ld_ready_o(ld_ready),
    .busy_o    (bus.o_busy),
    .tx_o      (bus.o_uart_tx)
  );

  assign bus.o_full    = full;
  assign bus.o_empty_n = empty_n;
  assign bus.o_ovf     = ovf_q;

`ifdef OUTBOX_DUMP_EN
  logic [LGFLEN-1:0] dmp_addr;
  logic [7:0]        dmp_data_q;
  logic              dmp_valid_q;

  // Position is relative to the oldest unsent byte; the sum wraps with the ring.
  assign dmp_addr = rd_ptr_q + bus.i_dmp_pos;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmp_data_q  <= 8'd0;
      dmp_valid_q <= 1'b0;
    end else begin
      dmp_data_q  <= mem[dmp_addr];
      dmp_valid_q <= ({1'b0, bus.i_dmp_pos} < count_q);
    end
  end

  assign bus.o_dmp_data  = dmp_data_q;
  assign bus.o_dmp_valid = dmp_valid_q;
`else
  logic unused_dmp_pos;

  assign unused_dmp_pos  = ^bus.i_dmp_pos;
  assign bus.o_dmp_data  = 8'd0;
  assign bus.o_dmp_valid = 1'b0;
`endif

endmodule

// File: tb/tb_outbox_uart_tx.sv
// Self-checking bench for outbox_uart_tx at a divider of 4: a line monitor
// decodes frames against a queue of expected bytes, plus directed corner cases.
module tb_outbox_uart_tx;

  localparam int unsigned LGFLEN = 5;
  localparam int          CPB    = 4;

  typedef struct {
    logic [LGFLEN-1:0] pos;
    logic [7:0]        data;
    logic              valid;
    logic              chk_data;
  } dvec_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_err;

  logic [7:0] exp_q[$];
  int         start_cyc_q[$];
  bit         discard;
  int         busy_rise_cyc;
  int         busy_fall_cyc;
  bit         busy_prev;
  int         ovf_cnt;

  outbox_uart_tx_if #(.LGFLEN(LGFLEN)) bus ();

  outbox_uart_tx #(
    .CLOCKS_PER_BAUD(24'd4),
    .LGFLEN         (LGFLEN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Busy edges and overflow pulses, sampled away from the active edge.
  initial begin
    busy_prev = 1'b0;
    ovf_cnt   = 0;
    forever begin
      @(negedge clk);
      if (bus.o_busy === 1'b1 && !busy_prev) busy_rise_cyc = cyc;
      if (bus.o_busy === 1'b0 && busy_prev) busy_fall_cyc = cyc;
      busy_prev = (bus.o_busy === 1'b1);
      if (bus.o_ovf === 1'b1) ovf_cnt++;
    end
  end

  // Line monitor: finds the start edge, samples each bit mid-period, pops the scoreboard.
  initial begin
    logic       prev;
    logic [7:0] b;
    logic       ok_start;
    logic       ok_stop;
    bit         d;
    int         st;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && prev && bus.o_uart_tx === 1'b0) begin
        st = cyc;
        d  = discard;
        repeat (2) @(negedge clk);
        ok_start = (bus.o_uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.o_uart_tx;
        end
        repeat (CPB) @(negedge clk);
        ok_stop = (bus.o_uart_tx === 1'b1);
        if (!d) begin
          start_cyc_q.push_back(st);
          $display("frame @%0d: byte 0x%02h", st, b);
          check("mon_start_bit", {31'd0, ok_start}, 32'd1);
          check("mon_stop_bit", {31'd0, ok_stop}, 32'd1);
          if (exp_q.size() == 0) begin
            check("mon_spurious_frame", {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            check("mon_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
        end
        prev = 1'b1;
      end else begin
        prev = (bus.o_uart_tx !== 1'b0);
      end
    end
  end

  task automatic drive_push(input logic [7:0] d, input bit expect_it);
    bus.i_wr   = 1'b1;
    bus.i_data = d;
    if (expect_it) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.o_busy !== 1'b0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && bus.o_busy === 1'b0)}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    dvec_t      dvec [5];
    logic [9:0] pat55;
    int         bad;
    int         ovf_base;

    n_checks = 0;
    n_err    = 0;
    discard  = 1'b0;
    reset_n  = 1'b0;
    bus.i_wr      = 1'b0;
    bus.i_data    = 8'd0;
    bus.i_dmp_pos = '0;

`ifdef OUTBOX_DUMP_EN
    dvec[0] = '{pos: 5'd0,  data: 8'h10, valid: 1'b1, chk_data: 1'b1};
    dvec[1] = '{pos: 5'd1,  data: 8'h20, valid: 1'b1, chk_data: 1'b1};
    dvec[2] = '{pos: 5'd2,  data: 8'h30, valid: 1'b1, chk_data: 1'b1};
    dvec[3] = '{pos: 5'd3,  data: 8'h00, valid: 1'b0, chk_data: 1'b0};
    dvec[4] = '{pos: 5'd31, data: 8'h00, valid: 1'b0, chk_data: 1'b0};
`else
    dvec[0] = '{pos: 5'd0,  data: 8'h00, valid: 1'b0, chk_data: 1'b1};
    dvec[1] = '{pos: 5'd1,  data: 8'h00, valid: 1'b0, chk_data: 1'b1};
    dvec[2] = '{pos: 5'd2,  data: 8'h00, valid: 1'b0, chk_data: 1'b1};
    dvec[3] = '{pos: 5'd3,  data: 8'h00, valid: 1'b0, chk_data: 1'b1};
    dvec[4] = '{pos: 5'd31, data: 8'h00, valid: 1'b0, chk_data: 1'b1};
`endif
    // start, 8 data bits LSB first, stop: index 0 is sent first
    pat55 = 10'b1_0101_0101_0;

    // ---- reset values and a long quiet idle
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {31'd0, bus.o_uart_tx}, 32'd1);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_empty_n", {31'd0, bus.o_empty_n}, 32'd0);
    check("rst_full", {31'd0, bus.o_full}, 32'd0);
    check("rst_ovf", {31'd0, bus.o_ovf}, 32'd0);
    check("rst_dmp_valid", {31'd0, bus.o_dmp_valid}, 32'd0);
    check("rst_dmp_data", {24'd0, bus.o_dmp_data}, 32'd0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.o_uart_tx !== 1'b1 || bus.o_empty_n !== 1'b0 || bus.o_busy !== 1'b0) bad++;
    end
    check("idle_2000_cycles", bad, 0);

    // ---- single byte 0x55: latency and per-cycle line shape
    drive_push(8'h55, 1'b1);
    bus.i_wr = 1'b0;
    @(negedge clk);
    check("p55_busy_after_pop", {31'd0, bus.o_busy}, 32'd1);
    check("p55_line_high_at_pop", {31'd0, bus.o_uart_tx}, 32'd1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        check($sformatf("p55_bit%0d_cyc%0d", b, c), {31'd0, bus.o_uart_tx}, {31'd0, pat55[b]});
      end
    end
    check("p55_busy_after_stop", {31'd0, bus.o_busy}, 32'd0);
    @(negedge clk);
    check("p55_idle_line", {31'd0, bus.o_uart_tx}, 32'd1);
    check("p55_frame_len", busy_fall_cyc - busy_rise_cyc, 10 * CPB);
    wait_drain(200, "p55_drain");

    // ---- three back-to-back frames
    start_cyc_q.delete();
    drive_push(8'h41, 1'b1);
    drive_push(8'h42, 1'b1);
    drive_push(8'h43, 1'b1);
    bus.i_wr = 1'b0;
    wait_drain(600, "b2b_drain");
    check("b2b_total_cycles", busy_fall_cyc - busy_rise_cyc, 3 * 10 * CPB);
    check("b2b_frame_count", start_cyc_q.size(), 3);
    if (start_cyc_q.size() == 3) begin
      check("b2b_gap_1", start_cyc_q[1] - start_cyc_q[0], 10 * CPB);
      check("b2b_gap_2", start_cyc_q[2] - start_cyc_q[1], 10 * CPB);
    end

    // ---- fill past capacity while frame 1 is on the line
    ovf_base = ovf_cnt;
    for (int i = 0; i < 34; i++) begin
      drive_push(8'h80 + 8'(i), (i < 33));
      if (i == 31) check("ovf_not_full_at_31", {31'd0, bus.o_full}, 32'd0);
      if (i == 32) begin
        check("ovf_full_at_32", {31'd0, bus.o_full}, 32'd1);
        check("ovf_no_pulse_at_32", {31'd0, bus.o_ovf}, 32'd0);
      end
      if (i == 33) begin
        check("ovf_pulse_at_33", {31'd0, bus.o_ovf}, 32'd1);
        check("ovf_still_full", {31'd0, bus.o_full}, 32'd1);
      end
    end
    bus.i_wr = 1'b0;
    @(negedge clk);
    check("ovf_pulse_ends", {31'd0, bus.o_ovf}, 32'd0);
    check("ovf_pulse_count", ovf_cnt - ovf_base, 1);
    wait_drain(3000, "ovf_drain");

    // ---- dump window while one frame is in flight
    drive_push(8'h99, 1'b1);
    drive_push(8'h10, 1'b1);
    drive_push(8'h20, 1'b1);
    drive_push(8'h30, 1'b1);
    bus.i_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.i_dmp_pos = dvec[i].pos;
      @(negedge clk);
      check($sformatf("dmp_valid_pos%0d", dvec[i].pos), {31'd0, bus.o_dmp_valid}, {31'd0, dvec[i].valid});
      if (dvec[i].chk_data)
        check($sformatf("dmp_data_pos%0d", dvec[i].pos), {24'd0, bus.o_dmp_data}, {24'd0, dvec[i].data});
    end
    bus.i_dmp_pos = '0;
    wait_drain(600, "dmp_drain");

    // ---- asynchronous reset in the middle of a data bit
    discard = 1'b1;
    drive_push(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) drive_push(8'hC0 + 8'(i), 1'b0);
    bus.i_wr = 1'b0;
    repeat (7) @(negedge clk);
    check("rst_mid_line_low_before", {31'd0, bus.o_uart_tx}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_line_high_async", {31'd0, bus.o_uart_tx}, 32'd1);
    check("rst_mid_flushed_async", {31'd0, bus.o_empty_n}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_empty_after", {31'd0, bus.o_empty_n}, 32'd0);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.o_uart_tx !== 1'b1 || bus.o_busy !== 1'b0) bad++;
    end
    check("rst_mid_no_frames", bad, 0);
    discard = 1'b0;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
